// File: rtl/fft_frame_out.sv
// Keeps the positive-frequency half of each NFFT-point frame and buffers it in
// an output FIFO with a registered first-word-fall-through read port.
module fft_frame_out #(
    parameter int BIT_WIDTH = 32,
    parameter int NFFT      = 1024,
    parameter int DEPTH     = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4:0]           RANGEBIN_NUM,
    input  logic [BIT_WIDTH-1:0] data_in,
    input  logic                 data_valid,
    output logic [BIT_WIDTH-1:0] data_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 frame_done,
    output logic                 busy,
    output logic                 overflow
);

    localparam int PW = $clog2(NFFT);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [3:0] {
        S_IDLE    = 4'b0001,
        S_CAPTURE = 4'b0010,
        S_DISCARD = 4'b0100,
        S_DONE    = 4'b1000
    } state_t;

    state_t state_q, state_d;

    logic [PW-1:0]    point_cnt_q, point_cnt_d;
    logic [4:0]       bin_cnt_q, bin_cnt_d;
    logic [4:0]       bins_q, bins_d;
    logic             overflow_q, overflow_d;
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [BIT_WIDTH:0] mem_q [DEPTH];
    logic [BIT_WIDTH-1:0] head_data_q, head_data_d;
    logic             head_tag_q, head_tag_d;
    logic             out_valid_q, out_valid_d;

    logic beat, last_capture, last_point, last_bin, full;
    logic capture_beat, discard_beat, wr_en, rd_en;
    logic [BIT_WIDTH:0] wr_word;

    // A beat coinciding with start is ignored in every state.
    assign beat         = data_valid & ~start;
    assign last_capture = (point_cnt_q == PW'(NFFT/2 - 1));
    assign last_point   = (point_cnt_q == {PW{1'b1}});
    assign last_bin     = ((bin_cnt_q + 5'd1) == bins_q);
    assign full         = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                          (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = S_CAPTURE;
        end else begin
            case (state_q)
                S_IDLE:    state_d = S_IDLE;
                S_CAPTURE: if (beat && last_capture) state_d = S_DISCARD;
                S_DISCARD: if (beat && last_point)   state_d = last_bin ? S_DONE : S_CAPTURE;
                S_DONE:    state_d = S_IDLE;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        frame_done   = (state_q == S_DONE);
        busy         = (state_q == S_CAPTURE) || (state_q == S_DISCARD);
        capture_beat = (state_q == S_CAPTURE) && beat;
        discard_beat = (state_q == S_DISCARD) && beat;
    end

    always_comb begin
        point_cnt_d = point_cnt_q;
        bin_cnt_d   = bin_cnt_q;
        bins_d      = bins_q;
        overflow_d  = overflow_q;
        wr_en       = 1'b0;
        wr_word     = {last_bin && last_capture, data_in};
        if (start) begin
            point_cnt_d = '0;
            bin_cnt_d   = '0;
            bins_d      = (RANGEBIN_NUM == 5'd0) ? 5'd1 : RANGEBIN_NUM;
            overflow_d  = 1'b0;
        end else if (capture_beat) begin
            point_cnt_d = point_cnt_q + PW'(1);
            if (full) overflow_d = 1'b1;
            else      wr_en      = 1'b1;
        end else if (discard_beat) begin
            point_cnt_d = point_cnt_q + PW'(1);
            if (last_point) bin_cnt_d = bin_cnt_q + 5'd1;
        end
    end

    // Head register mirrors mem[rd_ptr]; rd_ptr only moves on a transfer, so the
    // head slot counts toward the DEPTH-word capacity.
    always_comb begin
        rd_en       = out_valid_q & out_ready;
        rd_ptr_d    = rd_ptr_q + {{AW{1'b0}}, rd_en};
        wr_ptr_d    = wr_ptr_q + {{AW{1'b0}}, wr_en};
        out_valid_d = (wr_ptr_q != rd_ptr_d);
        head_data_d = head_data_q;
        head_tag_d  = head_tag_q;
        if (start) begin
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            out_valid_d = 1'b0;
        end
        if (out_valid_d) begin
            head_data_d = mem_q[rd_ptr_d[AW-1:0]][BIT_WIDTH-1:0];
            head_tag_d  = mem_q[rd_ptr_d[AW-1:0]][BIT_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            point_cnt_q <= '0;
            bin_cnt_q   <= '0;
            bins_q      <= '0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            head_data_q <= '0;
            head_tag_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            point_cnt_q <= point_cnt_d;
            bin_cnt_q   <= bin_cnt_d;
            bins_q      <= bins_d;
            overflow_q  <= overflow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            head_data_q <= head_data_d;
            head_tag_q  <= head_tag_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign data_out  = head_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_valid_q & head_tag_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_fft_frame_out.sv
// Directed bench for fft_frame_out with a queue-based reference of kept words.
module tb_fft_frame_out;

    localparam int BW    = 32;
    localparam int NFFT  = 1024;
    localparam int DEPTH = 1024;

    logic          clk, rst, start, data_valid, out_ready;
    logic [4:0]    RANGEBIN_NUM;
    logic [BW-1:0] data_in, data_out;
    logic          out_valid, out_last, frame_done, busy, overflow;

    fft_frame_out #(.BIT_WIDTH(BW), .NFFT(NFFT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .RANGEBIN_NUM(RANGEBIN_NUM),
        .data_in(data_in), .data_valid(data_valid), .data_out(data_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .frame_done(frame_done), .busy(busy), .overflow(overflow)
    );

    int tests = 0;
    int fails = 0;
    int rcv_cnt = 0;
    int fd_cnt = 0;
    int fd0;
    int rdy_mode = 1;
    logic [BW:0] exp_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // 0: stalled, 1: always ready, 2: toggling every cycle
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = ~out_ready;
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (frame_done) fd_cnt++;
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_valid", {63'd0, out_valid}, 64'd0);
                    end else if (out_ready) begin
                        check("word", {31'd0, out_last, data_out}, {31'd0, exp_q.pop_front()});
                        rcv_cnt++;
                    end else begin
                        check("stall_hold", {31'd0, out_last, data_out}, {31'd0, exp_q[0]});
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            data_valid = 1'b0;
        end
    endtask

    task automatic drive_beat(input logic [BW-1:0] d, input bit keep, input bit last);
        tick();
        data_valid = 1'b1;
        data_in    = d;
        if (keep && exp_q.size() < DEPTH) exp_q.push_back({last, d});
    endtask

    task automatic send_bin(input int b, input int nb, input logic [BW-1:0] base,
                            input bit gaps, input int npts);
        for (int i = 0; i < npts; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            drive_beat(base + BW'(i), i < NFFT/2, (b == nb - 1) && (i == NFFT/2 - 1));
        end
    endtask

    task automatic pulse_start(input logic [4:0] n, input bit with_beat);
        tick();
        start        = 1'b1;
        RANGEBIN_NUM = n;
        data_valid   = with_beat;
        data_in      = 32'hDEAD_BEEF;
        tick();
        start      = 1'b0;
        data_valid = 1'b0;
        exp_q.delete();
        rcv_cnt = 0;
        fd0     = fd_cnt;
        @(negedge clk);
        check("busy_rise", {63'd0, busy}, 64'd1);
        check("flush_valid", {63'd0, out_valid}, 64'd0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; RANGEBIN_NUM = '0; data_in = '0; data_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data_out", 64'(data_out), 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_last", {63'd0, out_last}, 64'd0);
        check("rst_frame_done", {63'd0, frame_done}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_overflow", {63'd0, overflow}, 64'd0);
        tick(); rst = 1'b0;
        idle(2);

        // single bin, contiguous beats
        pulse_start(5'd1, 1'b0);
        send_bin(0, 1, 32'd0, 1'b0, NFFT);
        idle(1);
        @(negedge clk);
        check("t1_frame_done", {63'd0, frame_done}, 64'd1);
        check("t1_busy_fall", {63'd0, busy}, 64'd0);
        wait_drain();
        check("t1_count", 64'(rcv_cnt), 64'd512);
        check("t1_fd_once", 64'(fd_cnt - fd0), 64'd1);
        check("t1_overflow", {63'd0, overflow}, 64'd0);

        // three bins with random gaps
        pulse_start(5'd3, 1'b0);
        for (int b = 0; b < 3; b++) send_bin(b, 3, BW'(b * 1024), 1'b1, NFFT);
        idle(3);
        wait_drain();
        check("t2_count", 64'(rcv_cnt), 64'd1536);
        check("t2_fd_once", 64'(fd_cnt - fd0), 64'd1);
        check("t2_overflow", {63'd0, overflow}, 64'd0);

        // four bins with consumer stalled: second half of kept words dropped
        rdy_mode = 0;
        idle(2);
        pulse_start(5'd4, 1'b0);
        for (int b = 0; b < 4; b++) send_bin(b, 4, BW'(b * 1024), 1'b0, NFFT);
        idle(3);
        @(negedge clk);
        check("t3_overflow", {63'd0, overflow}, 64'd1);
        check("t3_fd_once", 64'(fd_cnt - fd0), 64'd1);
        check("t3_held", 64'(exp_q.size()), 64'd1024);
        check("t3_head_last", {63'd0, out_last}, 64'd0);
        rdy_mode = 1;
        wait_drain();
        check("t3_count", 64'(rcv_cnt), 64'd1024);

        // new start clears overflow; consumer toggles ready every cycle
        rdy_mode = 2;
        pulse_start(5'd1, 1'b0);
        check("t4_overflow_clr", {63'd0, overflow}, 64'd0);
        send_bin(0, 1, 32'h100, 1'b0, NFFT);
        idle(2);
        wait_drain();
        check("t4_count", 64'(rcv_cnt), 64'd512);
        rdy_mode = 1;

        // abort mid bin 2 with a beat in the start cycle
        pulse_start(5'd3, 1'b0);
        send_bin(0, 3, 32'd0, 1'b0, NFFT);
        send_bin(1, 3, 32'd1024, 1'b0, NFFT);
        rdy_mode = 0;
        send_bin(2, 3, 32'd2048, 1'b0, 100);
        check("t5_abort_fd", 64'(fd_cnt - fd0), 64'd0);
        pulse_start(5'd1, 1'b1);
        rdy_mode = 1;
        send_bin(0, 1, 32'h5000, 1'b0, NFFT);
        idle(2);
        wait_drain();
        check("t5_count", 64'(rcv_cnt), 64'd512);
        check("t5_fd_once", 64'(fd_cnt - fd0), 64'd1);

        // async reset mid capture, then RANGEBIN_NUM=0 behaves as one bin
        rdy_mode = 0;
        pulse_start(5'd2, 1'b0);
        send_bin(0, 2, 32'h1234_0000, 1'b0, 50);
        idle(1);
        @(negedge clk);
        check("t6_pre_valid", {63'd0, out_valid}, 64'd1);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_valid", {63'd0, out_valid}, 64'd0);
        check("t6_rst_data", 64'(data_out), 64'd0);
        check("t6_rst_last", {63'd0, out_last}, 64'd0);
        check("t6_rst_busy", {63'd0, busy}, 64'd0);
        check("t6_rst_fd", {63'd0, frame_done}, 64'd0);
        check("t6_rst_ovf", {63'd0, overflow}, 64'd0);
        exp_q.delete();
        tick(); rst = 1'b0;
        rdy_mode = 1;
        idle(2);
        pulse_start(5'd0, 1'b0);
        send_bin(0, 1, 32'h7000, 1'b0, NFFT);
        idle(1);
        @(negedge clk);
        check("t6_frame_done", {63'd0, frame_done}, 64'd1);
        wait_drain();
        check("t6_count", 64'(rcv_cnt), 64'd512);
        check("t6_fd_once", 64'(fd_cnt - fd0), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fft_frame_out.md
# fft_frame_out

Output-side counterpart of the zero-padding input buffer. It consumes the NFFT-point frame stream for each range bin from the FFT/power stage and keeps only the positive-frequency half (points 0..NFFT/2-1) of each frame. The kept words go into an output FIFO with a ready/valid read interface for the upload path. It counts range bins per pulse and flags completion and overflow.

## Interface
- BIT_WIDTH, 32: width of one spectral word in and out
- NFFT, 1024: points per incoming frame (power of two)
- DEPTH, 1024: output FIFO depth in words (power of two, ≥ NFFT/2)
- clk  input  1  single clock for all logic
- rst  input  1  reset; asynchronous, active-high
- start  input  1  one-cycle pulse; arms capture for one pulse (all range bins)
- RANGEBIN_NUM  input  5  range bins per pulse, 1..16; sampled on start; 0 is treated as 1
- data_in  input  BIT_WIDTH  spectral word
- data_valid  input  1  data_in is a frame point this cycle (a beat); gaps allowed
- data_out  output  BIT_WIDTH  FIFO head word
- out_valid  output  1  data_out holds a valid word
- out_ready  input  1  consumer accepts; transfer when out_valid & out_ready
- out_last  output  1  qualifies data_out as the final kept word of the pulse
- frame_done  output  1  one-cycle pulse after the last beat of the last bin
- busy  output  1  high from the cycle after start until frame_done
- overflow  output  1  sticky; a kept word was dropped because the FIFO was full

## Operation
- State machine, one-hot: IDLE, CAPTURE, DISCARD, DONE.
- Counters: point_cnt (log2 NFFT bits) counts beats in the frame; bin_cnt (5 bits) counts completed frames; bins_reg latches RANGEBIN_NUM.
- IDLE: beats are ignored. start -> CAPTURE; point_cnt=0, bin_cnt=0, FIFO flushed, overflow cleared.
- CAPTURE: each beat is written to the FIFO and point_cnt increments. The beat with point_cnt==NFFT/2-1 moves to DISCARD.
- DISCARD: each beat is dropped and point_cnt increments. The beat with point_cnt==NFFT-1 wraps point_cnt to 0 and increments bin_cnt. If bin_cnt+1==bins_reg -> DONE; otherwise -> CAPTURE.
- DONE: frame_done=1 for one cycle, then -> IDLE.
- A start in any non-IDLE state aborts the pulse. Counters are re-armed as above, the FIFO is flushed, and the state goes to CAPTURE. A beat in the same cycle as start is ignored in every state.
- When the FIFO is full, a CAPTURE beat is dropped and overflow is set. Counters still advance, so frame alignment is preserved.
- The word written at point NFFT/2-1 of the last bin carries a stored last tag in the FIFO (BIT_WIDTH+1 bits wide). out_last = out_valid & tag of the head word.
- FIFO: DEPTH words, log2(DEPTH)+1-bit read and write pointers. Full means the MSBs differ and the rest are equal. Simultaneous write and read when full is a drop, because full is evaluated before the read.

## Timing
- Reset values: data_out=0, out_valid=0, out_last=0, frame_done=0, busy=0, overflow=0, state=IDLE, all counters 0, FIFO empty.
- busy rises the cycle after start and falls in the same cycle that frame_done is high.
- Write latency: a kept beat at cycle t is in the FIFO at t+1. out_valid rises at t+2 if the FIFO was empty (registered head).
- The read side is first-word-fall-through. data_out and out_valid hold while out_valid & !out_ready. After a transfer, the next word is presented the following cycle, sustaining 1 word/cycle.
- frame_done is high the cycle after the last DISCARD beat of the last bin.
- Reset mid-pulse discards all FIFO content immediately.
- Throughput: the input accepts one beat per cycle with no backpressure; the upstream never stalls.

## Test plan
- RANGEBIN_NUM=1, one 1024-beat frame with data=index, out_ready=1 -> 512 words 0..511 in order; out_last only on 511; frame_done once; no overflow.
- RANGEBIN_NUM=3, beats with random gaps, data=bin*1024+index -> 1536 words; each bin contributes only indices 0..511; out_last on word 2*1024+511.
- RANGEBIN_NUM=4, out_ready=0 throughout -> the FIFO holds 1024 words; the last 1024 kept words are dropped; overflow=1; frame_done still pulses. A later start clears overflow.
- out_ready toggling 1/0 every cycle -> data_out/out_valid are stable while stalled; no word is lost or duplicated versus the reference model.
- start asserted mid-bin-2, with a beat in the start cycle -> the FIFO is flushed, the start-cycle beat is ignored, and the next beat is stored as point 0 of bin 0.
- rst pulsed during CAPTURE with out_valid=1 -> all outputs return to their reset values asynchronously; RANGEBIN_NUM=0 on the next start behaves as 1 bin.
